psr_cc_unit: RTL and testbench

// - Processor State Register (SPARC layout) directly downstream of ALU_32bit: captures N/Z/V/C when the opcode S bit is set.
// - Feeds C back to the ALU carry input. Holds CWP, S, PS, ET, PIL, EF, EC and WIM.
// - Handles SAVE/RESTORE window moves, trap entry, RETT and the delayed WRPSR commit.

---
 rtl/psr_pkg.sv | 33 +++
 rtl/psr_cwp_ctrl.sv | 50 +++++
 rtl/psr_cc_unit.sv | 163 ++++++++++++++++
 tb/tb_psr_cc_unit.sv | 287 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/psr_pkg.sv
// PSR field positions, ALU opcode bit indices and the condition-code type
// shared by the processor-state-register block.
package psr_pkg;

    localparam int ICC_MSB  = 23;
    localparam int ICC_LSB  = 20;
    localparam int EC_BIT   = 13;
    localparam int EF_BIT   = 12;
    localparam int PIL_MSB  = 11;
    localparam int PIL_LSB  = 8;
    localparam int S_BIT    = 7;
    localparam int PS_BIT   = 6;
    localparam int ET_BIT   = 5;
    localparam int CWP_MSB  = 4;
    localparam int CWP_LSB  = 0;
    localparam int CWP_W    = 5;

    localparam int OP_S_BIT = 4;
    localparam int OP_X_BIT = 3;

    typedef struct packed {
        logic n;
        logic z;
        logic v;
        logic c;
    } icc_t;

    // Implemented-window mask: WIM bits at or above NWINDOWS do not exist.
    function automatic logic [31:0] wim_mask(input int nwin);
        return (nwin >= 32) ? 32'hFFFF_FFFF : ((32'd1 << nwin) - 32'd1);
    endfunction

endpackage

// File: rtl/psr_cwp_ctrl.sv
// Window pointer arithmetic: CWP +/-1 modulo NWINDOWS, WIM check of the target
// window and registered overflow/underflow pulses. Combinational targets, 1-cycle pulses.
module psr_cwp_ctrl
    import psr_pkg::*;
#(
    parameter int NWINDOWS = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [CWP_W-1:0] cwp_i,
    input  logic [31:0]      wim_i,
    input  logic             dec_req_i,
    input  logic             inc_req_i,
    output logic [CWP_W-1:0] cwp_dec_o,
    output logic [CWP_W-1:0] cwp_inc_o,
    output logic             dec_ok_o,
    output logic             inc_ok_o,
    output logic             win_ovf_o,
    output logic             win_unf_o
);

    localparam logic [CWP_W-1:0] CWP_MAX = CWP_W'(NWINDOWS - 1);

    logic ovf_q, ovf_d;
    logic unf_q, unf_d;

    assign cwp_dec_o = (cwp_i == '0)      ? CWP_MAX : cwp_i - CWP_W'(1);
    assign cwp_inc_o = (cwp_i == CWP_MAX) ? '0      : cwp_i + CWP_W'(1);

    assign dec_ok_o = ~wim_i[cwp_dec_o];
    assign inc_ok_o = ~wim_i[cwp_inc_o];

    // Requests arrive already priority-qualified, so a pulse means the move was refused.
    assign ovf_d = dec_req_i & ~dec_ok_o;
    assign unf_d = inc_req_i & ~inc_ok_o;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf_q <= 1'b0;
            unf_q <= 1'b0;
        end else begin
            ovf_q <= ovf_d;
            unf_q <= unf_d;
        end
    end

    assign win_ovf_o = ovf_q;
    assign win_unf_o = unf_q;

endmodule

// File: rtl/psr_cc_unit.sv
// SPARC PSR/WIM: icc capture, window moves, trap/RETT and WR_DELAY-deferred WRPSR commit.
// State updates one edge after the request; no backpressure, losing requests are dropped.
// ICC_BYPASS_EN forwards the same-cycle ALU carry to carry_out.
module psr_cc_unit
    import psr_pkg::*;
#(
    parameter int         NWINDOWS = 8,
    parameter int         WR_DELAY = 3,
    parameter logic [3:0] IMPL     = 4'h0,
    parameter logic [3:0] VER      = 4'h0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        alu_valid,
    input  logic [5:0]  alu_opcode,
    input  logic        alu_n,
    input  logic        alu_z,
    input  logic        alu_v,
    input  logic        alu_c,
    output logic        carry_out,
    input  logic        save,
    input  logic        restore,
    input  logic        trap,
    input  logic        rett,
    input  logic        wrpsr_en,
    input  logic [31:0] wrpsr_data,
    input  logic        wrwim_en,
    input  logic [31:0] wrwim_data,
    output logic [31:0] psr_out,
    output logic [31:0] wim_out,
    output logic        wr_busy,
    output logic        win_ovf,
    output logic        win_unf,
    output logic        bad_wr,
    output logic        error_mode
);

    localparam logic [31:0] WIM_MASK = wim_mask(NWINDOWS);

    icc_t             icc_q, icc_d;
    logic             ec_q, ec_d, ef_q, ef_d, s_q, s_d, ps_q, ps_d, et_q, et_d;
    logic [3:0]       pil_q, pil_d;
    logic [CWP_W-1:0] cwp_q, cwp_d;
    logic [31:0]      wim_q, wim_d;
    logic             busy_q, busy_d;
    logic [2:0]       cnt_q, cnt_d;
    logic [31:0]      wdat_q, wdat_d;
    logic             bad_q, bad_d, err_q, err_d;

    logic [CWP_W-1:0] cwp_dec, cwp_inc;
    logic             dec_ok, inc_ok;
    logic             commit, wr_bad, rett_go, sr_go, save_go, restore_go, icc_go;
    logic             unused_bits;

    assign commit     = ~err_q & ~trap & busy_q & (cnt_q == 3'd1) & ~wrpsr_en;
    assign wr_bad     = {27'd0, wdat_q[CWP_MSB:CWP_LSB]} >= 32'(NWINDOWS);
    assign rett_go    = ~err_q & ~trap & ~commit & rett;
    assign sr_go      = ~err_q & ~trap & ~commit & ~rett;
    assign save_go    = sr_go & save & ~restore;
    assign restore_go = sr_go & restore & ~save;
    assign icc_go     = sr_go & ~(save ^ restore) & alu_valid & alu_opcode[OP_S_BIT];

    psr_cwp_ctrl #(.NWINDOWS(NWINDOWS)) u_cwp (
        .clk       (clk),
        .rst_n     (rst_n),
        .cwp_i     (cwp_q),
        .wim_i     (wim_q),
        .dec_req_i (save_go),
        .inc_req_i (restore_go | rett_go),
        .cwp_dec_o (cwp_dec),
        .cwp_inc_o (cwp_inc),
        .dec_ok_o  (dec_ok),
        .inc_ok_o  (inc_ok),
        .win_ovf_o (win_ovf),
        .win_unf_o (win_unf)
    );

    // Lowest priority first; later blocks override earlier ones on the same edge.
    always_comb begin
        icc_d  = icc_q;  ec_d  = ec_q;  ef_d = ef_q;  pil_d = pil_q;
        s_d    = s_q;    ps_d  = ps_q;  et_d = et_q;  cwp_d = cwp_q;
        wim_d  = wim_q;  busy_d = busy_q; cnt_d = cnt_q; wdat_d = wdat_q;
        bad_d  = 1'b0;   err_d = err_q;
        if (!err_q && !(trap && !et_q) && wrwim_en)
            wim_d = wrwim_data & WIM_MASK;
        if (!err_q && !trap) begin
            if (busy_q)
                cnt_d = cnt_q - 3'd1;
            if (wrpsr_en) begin
                wdat_d = wrpsr_data;
                busy_d = 1'b1;
                cnt_d  = 3'(WR_DELAY);
            end
        end
        if (icc_go)
            icc_d = icc_t'({alu_n, alu_z, alu_v, alu_c});
        if (save_go && dec_ok)
            cwp_d = cwp_dec;
        if (restore_go && inc_ok)
            cwp_d = cwp_inc;
        if (rett_go && inc_ok) begin
            et_d  = 1'b1;
            s_d   = ps_q;
            cwp_d = cwp_inc;
        end
        if (commit) begin
            busy_d = 1'b0;
            if (wr_bad) begin
                bad_d = 1'b1;
            end else begin
                icc_d = icc_t'(wdat_q[ICC_MSB:ICC_LSB]);
                ec_d  = wdat_q[EC_BIT];
                ef_d  = wdat_q[EF_BIT];
                pil_d = wdat_q[PIL_MSB:PIL_LSB];
                s_d   = wdat_q[S_BIT];
                ps_d  = wdat_q[PS_BIT];
                et_d  = wdat_q[ET_BIT];
                cwp_d = wdat_q[CWP_MSB:CWP_LSB];
            end
        end
        if (!err_q && trap) begin
            if (et_q) begin
                et_d   = 1'b0;
                ps_d   = s_q;
                s_d    = 1'b1;
                cwp_d  = cwp_dec;
                busy_d = 1'b0;
            end else begin
                err_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            icc_q  <= '0;   ec_q  <= 1'b0; ef_q <= 1'b0; pil_q <= '0;
            s_q    <= 1'b1; ps_q  <= 1'b0; et_q <= 1'b0; cwp_q <= '0;
            wim_q  <= '0;   busy_q <= 1'b0; cnt_q <= '0; wdat_q <= '0;
            bad_q  <= 1'b0; err_q <= 1'b0;
        end else begin
            icc_q  <= icc_d;  ec_q  <= ec_d;   ef_q <= ef_d; pil_q <= pil_d;
            s_q    <= s_d;    ps_q  <= ps_d;   et_q <= et_d; cwp_q <= cwp_d;
            wim_q  <= wim_d;  busy_q <= busy_d; cnt_q <= cnt_d; wdat_q <= wdat_d;
            bad_q  <= bad_d;  err_q <= err_d;
        end
    end

`ifdef ICC_BYPASS_EN
    assign carry_out = (alu_valid & alu_opcode[OP_S_BIT]) ? alu_c : icc_q.c;
`else
    assign carry_out = icc_q.c;
`endif

    assign psr_out    = {IMPL, VER, icc_q, 6'b0, ec_q, ef_q, pil_q, s_q, ps_q, et_q, cwp_q};
    assign wim_out    = wim_q;
    assign wr_busy    = busy_q;
    assign bad_wr     = bad_q;
    assign error_mode = err_q;

    assign unused_bits = ^{alu_opcode[5], alu_opcode[OP_X_BIT], alu_opcode[2:0],
                           wdat_q[31:24], wdat_q[19:14]};

endmodule

// File: tb/tb_psr_cc_unit.sv
// Bench for psr_cc_unit: directed vector table, multi-cycle sequences, random vs. reference model.
module tb_psr_cc_unit;

    localparam int NW = 8;
    localparam int WD = 3;

    logic        clk, rst_n;
    logic        alu_valid, alu_n, alu_z, alu_v, alu_c;
    logic [5:0]  alu_opcode;
    logic        save, restore, trap, rett, wrpsr_en, wrwim_en;
    logic [31:0] wrpsr_data, wrwim_data;
    logic        carry_out, wr_busy, win_ovf, win_unf, bad_wr, error_mode;
    logic [31:0] psr_out, wim_out;

    psr_cc_unit #(.NWINDOWS(NW), .WR_DELAY(WD), .IMPL(4'h0), .VER(4'h0)) dut (
        .clk(clk), .rst_n(rst_n), .alu_valid(alu_valid), .alu_opcode(alu_opcode),
        .alu_n(alu_n), .alu_z(alu_z), .alu_v(alu_v), .alu_c(alu_c), .carry_out(carry_out),
        .save(save), .restore(restore), .trap(trap), .rett(rett),
        .wrpsr_en(wrpsr_en), .wrpsr_data(wrpsr_data), .wrwim_en(wrwim_en), .wrwim_data(wrwim_data),
        .psr_out(psr_out), .wim_out(wim_out), .wr_busy(wr_busy), .win_ovf(win_ovf),
        .win_unf(win_unf), .bad_wr(bad_wr), .error_mode(error_mode)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int nchk = 0;
    int nbad = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        nchk++;
        if (act !== exp) begin
            nbad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic idle();
        alu_valid = 1'b0; alu_opcode = 6'd0; {alu_n, alu_z, alu_v, alu_c} = 4'd0;
        save = 1'b0; restore = 1'b0; trap = 1'b0; rett = 1'b0;
        wrpsr_en = 1'b0; wrpsr_data = 32'd0; wrwim_en = 1'b0; wrwim_data = 32'd0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_reset();
        rst_n = 1'b0;
        #1;
        rst_n = 1'b1;
    endtask

    typedef struct {
        logic        valid;
        logic [5:0]  op;
        logic [3:0]  nzvc;
        logic        sv, rs, tr, rt, we;
        logic [7:0]  wd;
        logic [31:0] psr;
        logic [7:0]  wim;
        logic        ovf, unf, err;
    } vec_t;

    vec_t tbl [16];

    // ---------------- reference model ----------------
    logic [3:0]  m_icc, m_pil;
    logic        m_ec, m_ef, m_s, m_ps, m_et, m_err, m_ovf, m_unf, m_bad;
    int          m_cwp, m_pend_at, cyc;
    logic [31:0] m_pdat;
    logic        m_wim [NW];

    task automatic model_reset();
        m_icc = 4'd0; m_pil = 4'd0; m_ec = 1'b0; m_ef = 1'b0; m_s = 1'b1; m_ps = 1'b0;
        m_et = 1'b0; m_err = 1'b0; m_ovf = 1'b0; m_unf = 1'b0; m_bad = 1'b0;
        m_cwp = 0; m_pend_at = -1; m_pdat = 32'd0;
        for (int i = 0; i < NW; i++) m_wim[i] = 1'b0;
    endtask

    function automatic logic [31:0] m_psr();
        return {8'h00, m_icc, 6'b0, m_ec, m_ef, m_pil, m_s, m_ps, m_et, 5'(m_cwp)};
    endfunction

    function automatic logic [31:0] m_wimv();
        logic [31:0] r = 32'd0;
        for (int i = 0; i < NW; i++) r[i] = m_wim[i];
        return r;
    endfunction

    task automatic model_edge();
        int   tgt;
        logic commit;
        m_ovf = 1'b0; m_unf = 1'b0; m_bad = 1'b0;
        if (m_err) return;
        if (trap && !m_et) begin
            m_err = 1'b1;
            return;
        end
        commit = !trap && (m_pend_at == cyc) && !wrpsr_en;
        if (trap) begin
            m_et = 1'b0; m_ps = m_s; m_s = 1'b1; m_cwp = (m_cwp + NW - 1) % NW; m_pend_at = -1;
        end else if (commit) begin
            m_pend_at = -1;
            if (int'(m_pdat[4:0]) >= NW) m_bad = 1'b1;
            else begin
                m_icc = m_pdat[23:20]; m_ec = m_pdat[13]; m_ef = m_pdat[12]; m_pil = m_pdat[11:8];
                m_s = m_pdat[7]; m_ps = m_pdat[6]; m_et = m_pdat[5]; m_cwp = int'(m_pdat[4:0]);
            end
        end else if (rett) begin
            tgt = (m_cwp + 1) % NW;
            if (m_wim[tgt]) m_unf = 1'b1;
            else begin m_et = 1'b1; m_s = m_ps; m_cwp = tgt; end
        end else if (save && !restore) begin
            tgt = (m_cwp + NW - 1) % NW;
            if (m_wim[tgt]) m_ovf = 1'b1; else m_cwp = tgt;
        end else if (restore && !save) begin
            tgt = (m_cwp + 1) % NW;
            if (m_wim[tgt]) m_unf = 1'b1; else m_cwp = tgt;
        end else if (alu_valid && alu_opcode[4]) begin
            m_icc = {alu_n, alu_z, alu_v, alu_c};
        end
        if (!trap && wrpsr_en) begin
            m_pend_at = cyc + WD;
            m_pdat    = wrpsr_data;
        end
        if (wrwim_en)
            for (int i = 0; i < NW; i++) m_wim[i] = wrwim_data[i];
    endtask

    initial begin
        logic exp_c;

        tbl[0]  = '{1'b1, 6'b011000, 4'b0101, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 32'h0050_0080, 8'h00, 1'b0, 1'b0, 1'b0};
        tbl[1]  = '{1'b1, 6'b001000, 4'b1010, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 32'h0050_0080, 8'h00, 1'b0, 1'b0, 1'b0};
        tbl[2]  = '{1'b0, 6'b000000, 4'b0000, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 32'h0050_0087, 8'h00, 1'b0, 1'b0, 1'b0};
        tbl[3]  = '{1'b0, 6'b000000, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'h40, 32'h0050_0087, 8'h40, 1'b0, 1'b0, 1'b0};
        tbl[4]  = '{1'b0, 6'b000000, 4'b0000, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 32'h0050_0087, 8'h40, 1'b1, 1'b0, 1'b0};
        tbl[5]  = '{1'b0, 6'b000000, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 32'h0050_0087, 8'h40, 1'b0, 1'b0, 1'b0};
        tbl[6]  = '{1'b0, 6'b000000, 4'b0000, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 32'h0050_0080, 8'h40, 1'b0, 1'b0, 1'b0};
        tbl[7]  = '{1'b0, 6'b000000, 4'b0000, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 8'h04, 32'h0050_0081, 8'h04, 1'b0, 1'b0, 1'b0};
        tbl[8]  = '{1'b0, 6'b000000, 4'b0000, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 32'h0050_0081, 8'h04, 1'b0, 1'b1, 1'b0};
        tbl[9]  = '{1'b1, 6'b011000, 4'b1000, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 32'h0080_0081, 8'h04, 1'b0, 1'b0, 1'b0};
        tbl[10] = '{1'b0, 6'b000000, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 32'h0080_0081, 8'h04, 1'b0, 1'b1, 1'b0};
        tbl[11] = '{1'b0, 6'b000000, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'h00, 32'h0080_0081, 8'h00, 1'b0, 1'b0, 1'b0};
        tbl[12] = '{1'b0, 6'b000000, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 32'h0080_0022, 8'h00, 1'b0, 1'b0, 1'b0};
        tbl[13] = '{1'b0, 6'b000000, 4'b0000, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 32'h0080_0081, 8'h00, 1'b0, 1'b0, 1'b0};
        tbl[14] = '{1'b0, 6'b000000, 4'b0000, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 32'h0080_0081, 8'h00, 1'b0, 1'b0, 1'b1};
        tbl[15] = '{1'b1, 6'b011000, 4'b0001, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 8'hFF, 32'h0080_0081, 8'h00, 1'b0, 1'b0, 1'b1};

        idle();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset psr", psr_out, 32'h0000_0080);
        chk("reset wim", wim_out, 32'd0);
        chk("reset busy/ovf/unf/bad/err/carry",
            32'({wr_busy, win_ovf, win_unf, bad_wr, error_mode, carry_out}), 32'd0);
        rst_n = 1'b1;

        // directed vector table
        for (int i = 0; i < 16; i++) begin
            idle();
            alu_valid = tbl[i].valid; alu_opcode = tbl[i].op;
            {alu_n, alu_z, alu_v, alu_c} = tbl[i].nzvc;
            save = tbl[i].sv; restore = tbl[i].rs; trap = tbl[i].tr; rett = tbl[i].rt;
            wrwim_en = tbl[i].we; wrwim_data = {24'd0, tbl[i].wd};
            step();
            chk($sformatf("vec%0d psr", i), psr_out, tbl[i].psr);
            chk($sformatf("vec%0d wim", i), wim_out, {24'd0, tbl[i].wim});
            chk($sformatf("vec%0d ovf", i), 32'(win_ovf), 32'(tbl[i].ovf));
            chk($sformatf("vec%0d unf", i), 32'(win_unf), 32'(tbl[i].unf));
            chk($sformatf("vec%0d err", i), 32'(error_mode), 32'(tbl[i].err));
        end

        // reset asserted while in error mode
        idle();
        rst_n = 1'b0;
        #1;
        chk("async reset psr", psr_out, 32'h0000_0080);
        chk("async reset err", 32'(error_mode), 32'd0);
        rst_n = 1'b1;

        // reset discards a pending WRPSR
        wrpsr_en = 1'b1; wrpsr_data = 32'h0000_00A3;
        step(); idle();
        chk("pending busy", 32'(wr_busy), 32'd1);
        pulse_reset();
        chk("reset clears busy", 32'(wr_busy), 32'd0);
        repeat (4) step();
        chk("no commit after reset", psr_out, 32'h0000_0080);

        // WRPSR delay and commit overriding same-cycle ADDcc
        wrpsr_en = 1'b1; wrpsr_data = 32'h0000_00A3;
        step(); idle();
        chk("wr busy c1", 32'(wr_busy), 32'd1);
        step();
        chk("wr busy c2", 32'(wr_busy), 32'd1);
        step();
        chk("wr busy c3", 32'(wr_busy), 32'd1);
        chk("psr before commit", psr_out, 32'h0000_0080);
        alu_valid = 1'b1; alu_opcode = 6'b011000; {alu_n, alu_z, alu_v, alu_c} = 4'b1111;
        step(); idle();
        chk("wr busy cleared", 32'(wr_busy), 32'd0);
        chk("wr committed", psr_out, 32'h0000_00A3);

        // commit with CWP out of range is dropped
        wrpsr_en = 1'b1; wrpsr_data = 32'h0000_0009;
        step(); idle();
        step(); step(); step();
        chk("bad_wr pulse", 32'(bad_wr), 32'd1);
        chk("bad write psr", psr_out, 32'h0000_00A3);
        step();
        chk("bad_wr clears", 32'(bad_wr), 32'd0);

        // trap cancels a pending write
        wrpsr_en = 1'b1; wrpsr_data = 32'h0000_0080;
        step(); idle();
        trap = 1'b1;
        step(); idle();
        chk("trap cancels busy", 32'(wr_busy), 32'd0);
        chk("trap psr", psr_out, 32'h0000_00C2);
        repeat (4) step();
        chk("cancelled write stays dropped", psr_out, 32'h0000_00C2);

        // carry forwarding for an ADDcc/ADDX chain
        pulse_reset();
        alu_valid = 1'b1; alu_opcode = 6'b011000; {alu_n, alu_z, alu_v, alu_c} = 4'b0001;
        #1;
`ifdef ICC_BYPASS_EN
        chk("carry in ADDcc cycle", 32'(carry_out), 32'd1);
`else
        chk("carry in ADDcc cycle", 32'(carry_out), 32'd0);
`endif
        step();
        alu_opcode = 6'b001000; alu_c = 1'b0;
        #1;
        chk("carry in ADDX cycle", 32'(carry_out), 32'd1);
        step(); idle();

        // randomized run against the reference model
        pulse_reset();
        model_reset();
        cyc = 0;
        for (int k = 0; k < 2000; k++) begin
            alu_valid  = ($urandom_range(0, 1) == 1);
            alu_opcode = 6'($urandom);
            {alu_n, alu_z, alu_v, alu_c} = 4'($urandom);
            save       = ($urandom_range(0, 99) < 15);
            restore    = ($urandom_range(0, 99) < 15);
            rett       = ($urandom_range(0, 99) < 5);
            trap       = ($urandom_range(0, 99) < 3);
            wrwim_en   = ($urandom_range(0, 99) < 5);
            wrwim_data = $urandom & $urandom & $urandom;
            wrpsr_en   = ($urandom_range(0, 99) < 4);
            wrpsr_data = $urandom;
            wrpsr_data[4:0] = 5'($urandom_range(0, 9));
            #1;
`ifdef ICC_BYPASS_EN
            exp_c = (alu_valid && alu_opcode[4]) ? alu_c : m_icc[0];
`else
            exp_c = m_icc[0];
`endif
            chk("rnd carry", 32'(carry_out), 32'(exp_c));
            @(posedge clk);
            model_edge();
            cyc++;
            #1;
            chk("rnd psr", psr_out, m_psr());
            chk("rnd wim", wim_out, m_wimv());
            chk("rnd busy", 32'(wr_busy), 32'(m_pend_at != -1));
            chk("rnd ovf", 32'(win_ovf), 32'(m_ovf));
            chk("rnd unf", 32'(win_unf), 32'(m_unf));
            chk("rnd bad_wr", 32'(bad_wr), 32'(m_bad));
            chk("rnd err", 32'(error_mode), 32'(m_err));
            if (m_err) begin
                pulse_reset();
                model_reset();
            end
        end

        $display("test done: total=%0d bad=%0d", nchk, nbad);
        $finish;
    end

endmodule
